// File: rtl/q_operand_dispatcher.sv
// Snapshots NUM_OPS operands on a start edge, issues each on its own valid/ready channel,
// then collects one result (with optional timeout). One extra request can be queued while busy.
module q_operand_dispatcher #(
    parameter int DATA_W      = 32,
    parameter int NUM_OPS     = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [NUM_OPS*DATA_W-1:0] op_data,
    input  logic                      start,
    output logic [NUM_OPS-1:0]        m_op_tvalid,
    output logic [NUM_OPS*DATA_W-1:0] m_op_tdata,
    input  logic [NUM_OPS-1:0]        m_op_tready,
    input  logic [DATA_W-1:0]         s_res_tdata,
    input  logic                      s_res_tvalid,
    output logic                      s_res_tready,
    output logic [DATA_W-1:0]         result,
    output logic                      result_valid,
    output logic                      busy,
    output logic                      overrun,
    output logic                      timeout_err
);

    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RES = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic                        start_dly_q;
    logic [NUM_OPS-1:0]          tvalid_q, tvalid_d;
    logic [NUM_OPS-1:0]          done_q, done_d;
    logic [NUM_OPS*DATA_W-1:0]   act_q, act_d;
    logic [NUM_OPS*DATA_W-1:0]   pend_q, pend_d;
    logic                        pend_vld_q, pend_vld_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [DATA_W-1:0]           result_q, result_d;
    logic                        result_vld_q, result_vld_d;
    logic                        overrun_q, overrun_d;
    logic                        tmo_q, tmo_d;

    logic                        start_edge;
    logic [NUM_OPS-1:0]          hs;
    logic                        tmo_hit;
    logic                        launch;
    logic [NUM_OPS*DATA_W-1:0]   launch_dat;

    assign start_edge = start & ~start_dly_q;
    assign hs         = tvalid_q & m_op_tready;
    assign tmo_hit    = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC));

    always_comb begin
        state_d      = state_q;
        tvalid_d     = tvalid_q;
        done_d       = done_q;
        act_d        = act_q;
        pend_d       = pend_q;
        pend_vld_d   = pend_vld_q;
        cnt_d        = cnt_q;
        result_d     = result_q;
        result_vld_d = 1'b0;
        overrun_d    = 1'b0;
        tmo_d        = 1'b0;
        launch       = 1'b0;
        launch_dat   = op_data;

        case (state_q)
            IDLE: begin
                // A request queued on the very cycle WAIT_RES ended is launched from here.
                if (pend_vld_q) begin
                    launch     = 1'b1;
                    launch_dat = pend_q;
                    pend_vld_d = 1'b0;
                end
            end
            ISSUE: begin
                tvalid_d = tvalid_q & ~hs;
                done_d   = done_q | hs;
                if (&(done_q | hs)) begin
                    state_d = WAIT_RES;
                end
            end
            WAIT_RES: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (s_res_tvalid || tmo_hit) begin
                    cnt_d = '0;
                    if (s_res_tvalid) begin
                        result_d     = s_res_tdata;
                        result_vld_d = 1'b1;
                    end else begin
                        tmo_d = 1'b1;
                    end
                    if (pend_vld_q) begin
                        launch     = 1'b1;
                        launch_dat = pend_q;
                        pend_vld_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Pending occupancy is judged on the registered value, so a slot freed this cycle is not reused.
        if (start_edge) begin
            if (state_q == IDLE && !pend_vld_q) begin
                launch     = 1'b1;
                launch_dat = op_data;
            end else if (!pend_vld_q) begin
                pend_d     = op_data;
                pend_vld_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        if (launch) begin
            act_d    = launch_dat;
            tvalid_d = '1;
            done_d   = '0;
            state_d  = ISSUE;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= IDLE;
            start_dly_q  <= 1'b0;
            tvalid_q     <= '0;
            done_q       <= '0;
            act_q        <= '0;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            cnt_q        <= '0;
            result_q     <= '0;
            result_vld_q <= 1'b0;
            overrun_q    <= 1'b0;
            tmo_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_dly_q  <= start;
            tvalid_q     <= tvalid_d;
            done_q       <= done_d;
            act_q        <= act_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            cnt_q        <= cnt_d;
            result_q     <= result_d;
            result_vld_q <= result_vld_d;
            overrun_q    <= overrun_d;
            tmo_q        <= tmo_d;
        end
    end

    assign m_op_tvalid  = tvalid_q;
    assign m_op_tdata   = act_q;
    assign s_res_tready = (state_q == WAIT_RES);
    assign busy         = (state_q != IDLE);
    assign result       = result_q;
    assign result_valid = result_vld_q;
    assign overrun      = overrun_q;
    assign timeout_err  = tmo_q;

endmodule

// File: tb/tb_q_operand_dispatcher.sv
// Randomised and directed bench for q_operand_dispatcher against a job-level reference model.
module tb_q_operand_dispatcher;

    localparam int DW  = 32;
    localparam int NO  = 4;
    localparam int TMO = 8;

    logic            aclk;
    logic            areset;
    logic [NO*DW-1:0] op_data;
    logic            start;
    logic [NO-1:0]   m_op_tvalid;
    logic [NO*DW-1:0] m_op_tdata;
    logic [NO-1:0]   m_op_tready;
    logic [DW-1:0]   s_res_tdata;
    logic            s_res_tvalid;
    logic            s_res_tready;
    logic [DW-1:0]   result;
    logic            result_valid;
    logic            busy;
    logic            overrun;
    logic            timeout_err;

    q_operand_dispatcher #(.DATA_W(DW), .NUM_OPS(NO), .TIMEOUT_CYC(TMO)) dut (
        .aclk(aclk), .areset(areset), .op_data(op_data), .start(start),
        .m_op_tvalid(m_op_tvalid), .m_op_tdata(m_op_tdata), .m_op_tready(m_op_tready),
        .s_res_tdata(s_res_tdata), .s_res_tvalid(s_res_tvalid), .s_res_tready(s_res_tready),
        .result(result), .result_valid(result_valid), .busy(busy),
        .overrun(overrun), .timeout_err(timeout_err)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Reference model: one active job (operands + set of channels not yet accepted), a queue
    // of at most one waiting job, and the cycle count spent waiting for the result.
    logic [NO*DW-1:0] m_act = '0;
    logic [NO*DW-1:0] m_pend[$];
    bit               m_active = 0, m_waiting = 0, m_prev_start = 0;
    bit   [NO-1:0]    m_left = '0;
    int               m_wcnt = 0;
    logic [DW-1:0]    m_result = '0;
    bit               m_rv = 0, m_ov = 0, m_te = 0;

    task automatic m_launch(input logic [NO*DW-1:0] d);
        m_act     = d;
        m_active  = 1;
        m_waiting = 0;
        m_left    = '1;
    endtask

    initial begin
        forever begin
            @(posedge aclk or posedge areset);
            if (areset) begin
                m_act = '0; m_pend.delete(); m_active = 0; m_waiting = 0; m_prev_start = 0;
                m_left = '0; m_wcnt = 0; m_result = '0; m_rv = 0; m_ov = 0; m_te = 0;
            end else begin
                bit edge_s, was_active, pend_had, fin;
                edge_s       = start && !m_prev_start;
                m_prev_start = start;
                was_active   = m_active;
                pend_had     = (m_pend.size() != 0);
                m_rv = 0; m_ov = 0; m_te = 0;
                if (!m_active) begin
                    if (pend_had) m_launch(m_pend.pop_front());
                end else if (!m_waiting) begin
                    m_left = m_left & ~m_op_tready;
                    if (m_left == 0) begin
                        m_waiting = 1;
                        m_wcnt    = 0;
                    end
                end else begin
                    fin = 0;
                    if (s_res_tvalid) begin
                        m_result = s_res_tdata; m_rv = 1; fin = 1;
                    end else if (m_wcnt == TMO) begin
                        m_te = 1; fin = 1;
                    end else begin
                        m_wcnt++;
                    end
                    if (fin) begin
                        m_active = 0; m_waiting = 0;
                        if (pend_had) m_launch(m_pend.pop_front());
                    end
                end
                if (edge_s) begin
                    if (!was_active && !pend_had) m_launch(op_data);
                    else if (!pend_had) m_pend.push_back(op_data);
                    else m_ov = 1;
                end
            end
        end
    end

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    int rv_cnt = 0, ov_cnt = 0, te_cyc = -1;
    logic [NO-1:0]    first_rv_tvalid;
    logic [NO*DW-1:0] first_rv_tdata;
    int tr_mode = 1, res_mode = 0;
    logic [DW-1:0] res_val = '0;

    task automatic chk(input string nm, input logic [NO*DW-1:0] act, input logic [NO*DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [NO*DW-1:0] rnd_ops();
        logic [NO*DW-1:0] r;
        for (int i = 0; i < NO; i++) r[i*DW +: DW] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge aclk);
        #2;
    endtask

    initial begin
        int ks, rv0;
        logic [NO*DW-1:0] x_ops;
        areset = 1'b1; start = 1'b0; op_data = '0; m_op_tready = '0;
        s_res_tdata = '0; s_res_tvalid = 1'b0;
        #3;
        chk("rst_tvalid", m_op_tvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_tready", s_res_tready, 0);

        fork
            forever begin
                @(negedge aclk);
                cyc++;
                if (!areset) begin
                    chk("tvalid", m_op_tvalid, (m_active && !m_waiting) ? m_left : 0);
                    chk("tdata", m_op_tdata, m_act);
                    chk("s_res_tready", s_res_tready, m_active && m_waiting);
                    chk("busy", busy, m_active);
                    chk("result", result, m_result);
                    chk("result_valid", result_valid, m_rv);
                    chk("overrun", overrun, m_ov);
                    chk("timeout_err", timeout_err, m_te);
                    if (result_valid) begin
                        if (rv_cnt == 0) begin
                            first_rv_tvalid = m_op_tvalid;
                            first_rv_tdata  = m_op_tdata;
                        end
                        rv_cnt++;
                    end
                    if (overrun) ov_cnt++;
                    if (timeout_err) te_cyc = cyc;
                end
            end
            forever begin
                @(posedge aclk);
                #2;
                if (tr_mode == 1) m_op_tready = '1;
                else if (tr_mode == 2) m_op_tready = NO'($urandom);
                case (res_mode)
                    0: s_res_tvalid = 1'b0;
                    1: begin s_res_tvalid = s_res_tready; s_res_tdata = res_val; end
                    2: begin s_res_tvalid = ($urandom_range(3) == 0); s_res_tdata = $urandom; end
                    default: s_res_tvalid = 1'b1;
                endcase
            end
        join_none

        repeat (2) tick();
        areset = 1'b0;
        repeat (2) tick();

        // Single op, all ready, immediate result.
        tr_mode = 1; res_mode = 1; res_val = 32'hA;
        op_data = {32'd4, 32'd3, 32'd2, 32'd1};
        start = 1'b1;
        tick(); #2;
        chk("t1_tvalid_k1", m_op_tvalid, 4'hF);
        chk("t1_tdata_k1", m_op_tdata, {32'd4, 32'd3, 32'd2, 32'd1});
        tick(); #2;
        chk("t1_tvalid_k2", m_op_tvalid, 0);
        chk("t1_sready_k2", s_res_tready, 1);
        tick(); #2;
        chk("t1_result_k3", result, 32'hA);
        chk("t1_rvalid_k3", result_valid, 1);
        tick(); #2;
        chk("t1_busy_k4", busy, 0);
        start = 1'b0;
        repeat (3) tick();

        // Staggered readies.
        tr_mode = 0; m_op_tready = '0; op_data = rnd_ops();
        start = 1'b1;
        tick(); m_op_tready = 4'b0001; start = 1'b0; #2;
        chk("t2_tvalid_k1", m_op_tvalid, 4'b1111);
        tick(); m_op_tready = 4'b0000; #2;
        chk("t2_tvalid_k2", m_op_tvalid, 4'b1110);
        tick(); m_op_tready = 4'b0110; #2;
        tick(); m_op_tready = 4'b0000; #2;
        chk("t2_tvalid_k4", m_op_tvalid, 4'b1000);
        tick(); m_op_tready = 4'b1000; #2;
        chk("t2_sready_k5", s_res_tready, 0);
        tick(); m_op_tready = 4'b0000; #2;
        chk("t2_tvalid_k6", m_op_tvalid, 0);
        chk("t2_sready_k6", s_res_tready, 1);
        repeat (3) tick();

        // Queued request and overrun.
        tr_mode = 1; res_mode = 0; res_val = 32'h1234; rv_cnt = 0; ov_cnt = 0;
        op_data = rnd_ops();
        start = 1'b1;
        tick(); start = 1'b0;
        tick(); op_data = {32'd8, 32'd7, 32'd6, 32'd5}; start = 1'b1;
        tick(); start = 1'b0; op_data = rnd_ops();
        tick(); start = 1'b1;
        tick(); start = 1'b0; #2;
        chk("t3_overrun_pulse", overrun, 1);
        tick(); res_mode = 1;
        repeat (8) tick();
        chk("t3_overrun_cnt", ov_cnt, 1);
        chk("t3_rv_cnt", rv_cnt, 2);
        chk("t3_reissue_tvalid", first_rv_tvalid, 4'hF);
        chk("t3_reissue_tdata", first_rv_tdata, {32'd8, 32'd7, 32'd6, 32'd5});
        res_mode = 0;
        repeat (3) tick();

        // Timeout.
        te_cyc = -1; rv0 = rv_cnt;
        op_data = rnd_ops();
        start = 1'b1; ks = cyc;
        tick(); start = 1'b0;
        repeat (14) tick();
        chk("t4_te_cycle", te_cyc, ks + 12);
        chk("t4_result_held", result, 32'h1234);
        chk("t4_idle", busy, 0);
        res_mode = 3;
        repeat (4) tick();
        chk("t4_late_sready", s_res_tready, 0);
        chk("t4_late_no_rv", rv_cnt, rv0);
        res_mode = 0;
        repeat (2) tick();

        // Reset mid-issue.
        tr_mode = 0; m_op_tready = '0; res_mode = 1; op_data = rnd_ops();
        start = 1'b1;
        tick(); m_op_tready = 4'b0011; start = 1'b0;
        tick(); m_op_tready = 4'b0000; #2;
        chk("t5_partial", m_op_tvalid, 4'b1100);
        areset = 1'b1; #1;
        chk("t5_rst_tvalid", m_op_tvalid, 0);
        chk("t5_rst_tdata", m_op_tdata, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_result", result, 0);
        repeat (2) tick();
        areset = 1'b0; tr_mode = 1; rv_cnt = 0;
        tick();
        op_data = rnd_ops(); start = 1'b1;
        tick(); start = 1'b0; #2;
        chk("t5_fresh_tvalid", m_op_tvalid, 4'hF);
        repeat (4) tick();
        chk("t5_fresh_rv", rv_cnt, 1);

        // Start held high, then operand snapshot.
        rv_cnt = 0; op_data = rnd_ops(); start = 1'b1;
        repeat (20) tick();
        start = 1'b0;
        repeat (4) tick();
        chk("t6_one_op", rv_cnt, 1);
        x_ops = rnd_ops(); op_data = x_ops; start = 1'b1;
        tick(); op_data = ~x_ops; start = 1'b0; #2;
        chk("t6_snapshot", m_op_tdata, x_ops);
        repeat (4) tick();

        // Random traffic.
        tr_mode = 2; res_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (areset) areset = 1'b0;
            else if ($urandom_range(399) == 0) areset = 1'b1;
            if ($urandom_range(2) == 0) start = ~start;
            if ($urandom_range(3) == 0) op_data = rnd_ops();
        end
        tr_mode = 1; res_mode = 1; start = 1'b0;
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
